priority_grant_sequencer: RTL and testbench
===========================================

// Module: priority_grant_sequencer
// PURPOSE
//  Consumer-side counterpart of the combinational priority scheme. Accepts a
//  request vector over a valid/ready handshake and latches it. Then issues
//  one-hot grants one at a time in strict priority order: MSB first.
//  Each grant is handed off over a second valid/ready handshake. It
//  serialises a multi-bit request word into a stream of single grants.
// PARAMETERS
//  N    4    request/grant vector width (N >= 2)
// PORTS
//  clk        in   1         clock, all state updates on rising edge
//  reset      in   1         synchronous, active-high reset
//  req_valid  in   1         req holds a new request vector
//  req_ready  out  1         block can accept a vector this cycle
//  req        in   N         request vector, bit N-1 = highest priority
//  gnt_valid  out  1         gnt holds a valid grant
//  gnt_ready  in   1         downstream accepts gnt this cycle
//  gnt        out  N         one-hot grant; all-zero when gnt_valid=0
//  gnt_idx    out  clog2(N)  binary index of gnt (only with PRIO_SEQ_IDX_EN)
//  busy       out  1         pending vector non-zero
// BEHAVIOUR
//  - One clock: clk. Reset is synchronous and active-high on port reset.
//  - Reset (reset=1 at an edge) has the following effect:
//    - state<=IDLE, pend<=0.
//    - gnt_valid=0, gnt=0, gnt_idx=0, busy=0.
//    - req_ready=0 while reset is high.
//    - Reset overrides all handshakes, including mid-sequence.
//    - Pending bits are discarded; no grant is issued for them.
//  - Register pend[N-1:0] holds the not-yet-granted request bits.
//  - States:
//    - IDLE:  req_ready=1 (when reset=0). gnt_valid=0.
//      - req_valid=1 and req!=0: pend<=req, go to GRANT.
//      - req_valid=1 and req==0: vector is consumed and dropped. Stay in IDLE.
//    - GRANT: req_ready=0, gnt_valid=1.
//      - gnt = highest set bit of pend. This is the same mapping as the
//        priority scheme, e.g. pend=0111 -> gnt=0100.
//      - gnt_ready=1: pend <= pend & ~gnt.
//        - If the resulting pend==0, go to IDLE. Otherwise stay in GRANT.
//      - gnt_ready=0: gnt, pend and state hold unchanged (stall).
//  - Latency:
//    - Vector accepted at edge k -> first grant valid in cycle k+1.
//    - One grant per cycle while gnt_ready=1.
//  - Last grant accepted at edge m -> IDLE in cycle m+1. req_ready=1 from
//    cycle m+1, so there is no same-cycle overlap of request and grant.
//  - busy = (pend != 0). It equals the GRANT state.
//  - gnt and gnt_idx are driven from registered state only. There is no
//    combinational path from req or req_valid to any output.
//  - gnt_ready is ignored in IDLE. req_valid is ignored in GRANT.
// CONFIGURATION
//  - PRIO_SEQ_IDX_EN defined:
//    - Port gnt_idx exists and equals the bit position of gnt when
//      gnt_valid=1, e.g. gnt=0100 -> 2.
//    - gnt_idx is 0 when gnt_valid=0.
//  - PRIO_SEQ_IDX_EN undefined:
//    - Port gnt_idx and its logic are absent.
//    - All other behaviour is identical.
// TESTING
//  1. Reset, then req=1111, gnt_ready=1.
//     -> gnt=1000,0100,0010,0001 on 4 consecutive cycles.
//     -> Then gnt_valid=0 and req_ready=1.
//  2. req=0101, gnt_ready=0 for 3 cycles, then 1.
//     -> gnt=0100 held for 4 cycles, then gnt=0001, then IDLE.
//  3. req=0000 with req_valid=1.
//     -> Accepted (req_ready=1). gnt_valid stays 0 and busy stays 0.
//  4. req=1011; after the first grant (1000), assert reset for 1 cycle.
//     -> Next cycle: gnt_valid=0, gnt=0, busy=0, req_ready=1.
//     -> No grants 0010 or 0001 are issued.
//  5. Offer req=0001 while in GRANT for 0110.
//     -> req_ready=0 and the vector is not taken.
//     -> Held req accepted in the cycle after 0010 is granted.
//     -> gnt=0001 follows.
//  6. With PRIO_SEQ_IDX_EN: req=1111 -> gnt_idx=3,2,1,0.
//     -> gnt_idx=0 when gnt_valid=0.

Source files
------------

// File: rtl/priority_grant_sequencer_if.sv
// Handshake bundle for priority_grant_sequencer.
// Request side: req_valid/req_ready/req. Grant side: gnt_valid/gnt_ready/gnt.
// busy reports a non-zero pending vector.
// Optional macro PRIO_SEQ_IDX_EN adds gnt_idx, the binary index of gnt.
// The slave modport belongs to the sequencer. The master modport belongs to
// the environment that drives requests and accepts grants.
interface priority_grant_sequencer_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req;
  logic         gnt_valid;
  logic         gnt_ready;
  logic [N-1:0] gnt;
  logic         busy;
`ifdef PRIO_SEQ_IDX_EN
  logic [IW-1:0] gnt_idx;

  modport slave (
    input  req_valid, req, gnt_ready,
    output req_ready, gnt_valid, gnt, busy, gnt_idx
  );

  modport master (
    output req_valid, req, gnt_ready,
    input  req_ready, gnt_valid, gnt, busy, gnt_idx
  );
`else
  modport slave (
    input  req_valid, req, gnt_ready,
    output req_ready, gnt_valid, gnt, busy
  );

  modport master (
    output req_valid, req, gnt_ready,
    input  req_ready, gnt_valid, gnt, busy
  );
`endif
endinterface

// File: rtl/priority_grant_sequencer.sv
// priority_grant_sequencer
//
// Latches a request vector over a valid/ready handshake. It then hands out
// one-hot grants, highest set bit first, one per accepted grant handshake.
// A new vector is taken only once every pending bit has been granted.
//
// Grant outputs are registered. They are recomputed from the next pending
// value on the same edge that changes it. No path exists from req or
// req_valid to any output.
//
// Optional macro PRIO_SEQ_IDX_EN adds the gnt_idx output.
module priority_grant_sequencer #(
  parameter int N = 4
) (
  input logic                     clk,
  input logic                     reset,
  priority_grant_sequencer_if.slave bus
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [N-1:0]  pend;
  logic [N-1:0]  gnt_q;
  logic          gnt_valid_q;
  logic [N-1:0]  pend_next;

  // One-hot mask of the highest set bit of v; zero when v is zero.
  function automatic logic [N-1:0] top_bit(input logic [N-1:0] v);
    logic [N-1:0] r;
    // NOTE: r gets a default before the loop, so the result is fully defined
    // for every input. This keeps combinational users free of latches.
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Pending bits left after the current grant is accepted.
  assign pend_next = pend & ~gnt_q;

  // Main control: the pending vector, the state and the registered grant outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. Every register then
    // sees the pre-edge values of the others, whatever the statement order.
    if (reset) begin
      state       <= IDLE;
      pend        <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // An all-zero vector is consumed here without leaving IDLE.
          if (bus.req_valid && (bus.req != '0)) begin
            state       <= GRANT;
            pend        <= bus.req;
            gnt_q       <= top_bit(bus.req);
            gnt_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          // When gnt_ready is low, every register holds: this is the stall.
          if (bus.gnt_ready) begin
            pend <= pend_next;
            if (pend_next == '0) begin
              state       <= IDLE;
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
            end else begin
              gnt_q <= top_bit(pend_next);
            end
          end
        end
        default: begin
          state       <= IDLE;
          pend        <= '0;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset masks req_ready directly, so no vector is accepted while reset is held.
  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (pend != '0);

`ifdef PRIO_SEQ_IDX_EN
  logic [IW-1:0] idx_q;

  // Binary position of the next grant, tracked alongside gnt_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && (bus.req != '0)) begin
            idx_q <= '0;
            for (int i = 0; i < N; i++) begin
              if (bus.req[i]) idx_q <= IW'(i);
            end
          end
        end
        GRANT: begin
          if (bus.gnt_ready) begin
            idx_q <= '0;
            for (int i = 0; i < N; i++) begin
              if (pend_next[i]) idx_q <= IW'(i);
            end
          end
        end
        default: idx_q <= '0;
      endcase
    end
  end

  assign bus.gnt_idx = idx_q;
`endif

endmodule

// File: tb/tb_priority_grant_sequencer.sv
// Self-checking bench for priority_grant_sequencer.
// The reference model keeps only the set of not-yet-granted request bits.
// Every expected output is derived from that set. Directed scenarios come
// first, followed by a randomized run that includes occasional resets.
// Define PRIO_SEQ_IDX_EN to also check gnt_idx.
module tb_priority_grant_sequencer;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic clk;
  logic reset;

  priority_grant_sequencer_if #(.N(N)) ifc ();

  priority_grant_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the bits still waiting for a grant.
  logic [N-1:0] m_pend;

  // Position of the highest set bit, or -1 when none is set.
  function automatic int top_pos(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the value the model predicts for this cycle.
  task automatic check_outputs();
    int           p;
    logic [N-1:0] eg;
    p  = top_pos(m_pend);
    eg = '0;
    if (p >= 0) eg[p] = 1'b1;
    check("req_ready", 32'(ifc.req_ready), 32'((m_pend == '0) && !reset));
    check("gnt_valid", 32'(ifc.gnt_valid), 32'(p >= 0));
    check("gnt",       32'(ifc.gnt),       32'(eg));
    check("busy",      32'(ifc.busy),      32'(p >= 0));
`ifdef PRIO_SEQ_IDX_EN
    check("gnt_idx",   32'(ifc.gnt_idx),   (p >= 0) ? 32'(p) : 32'd0);
`endif
  endtask

  // Apply the rules to the inputs that are present at the clock edge.
  task automatic model_step();
    int p;
    if (reset) begin
      m_pend = '0;
    end else if (m_pend == '0) begin
      if (ifc.req_valid) m_pend = ifc.req;
    end else if (ifc.gnt_ready) begin
      p = top_pos(m_pend);
      m_pend[p] = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, then step the model on the rising edge.
  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic drive(input logic rv, input logic [N-1:0] r, input logic gr);
    ifc.req_valid = rv;
    ifc.req       = r;
    ifc.gnt_ready = gr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    m_pend = '0;
    @(posedge clk);
    #1;
    // Reset state while reset is still high.
    cycle(2);
    reset = 1'b0;
    cycle(1);

    // 1: all four bits are granted MSB first, back to back.
    drive(1'b1, 4'b1111, 1'b1);
    cycle(1);
    drive(1'b0, '0, 1'b1);
    cycle(5);

    // 2: the first grant is stalled for three cycles.
    drive(1'b1, 4'b0101, 1'b0);
    cycle(1);
    drive(1'b0, '0, 1'b0);
    cycle(3);
    ifc.gnt_ready = 1'b1;
    cycle(3);

    // 3: a zero vector is consumed and nothing is granted.
    drive(1'b1, 4'b0000, 1'b1);
    cycle(2);
    drive(1'b0, '0, 1'b0);
    cycle(1);

    // 4: reset in the middle of a sequence discards the remaining bits.
    drive(1'b1, 4'b1011, 1'b1);
    cycle(1);
    drive(1'b0, '0, 1'b1);
    cycle(1);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    cycle(3);

    // 5: a vector offered during GRANT waits until the block is IDLE again.
    drive(1'b1, 4'b0110, 1'b1);
    cycle(1);
    drive(1'b1, 4'b0001, 1'b1);
    cycle(3);
    drive(1'b0, '0, 1'b1);
    cycle(3);

    // Randomized traffic, including stalls, zero vectors and occasional resets.
    for (int t = 0; t < 600; t++) begin
      drive(1'($urandom_range(0, 1)), N'($urandom_range(0, (1 << N) - 1)),
            ($urandom_range(0, 9) < 7));
      reset = ($urandom_range(0, 49) == 0);
      cycle(1);
    end
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    cycle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
